ft2232h_axil_mem_responder: RTL and testbench

//  AXI4-Lite slave (responder) backing a small word-addressed register memory.
//  It is the far end of the m00_AXI initiator used by the FT2232H FIFO245 read path:
//  it accepts the initiator's write/read bursts of single beats and returns OKAY/SLVERR.
//  It replaces the VIP slave in the BFM design, so the initiator's pass/fail self-check

---
 rtl/ft2232h_axil_mem_responder.sv | 193 +++++++++++++++++++
 tb/tb_ft2232h_axil_mem_responder.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/ft2232h_axil_mem_responder.sv
// rtl/ft2232h_axil_mem_responder.sv - AXI4-Lite responder backed by a small word-addressed register memory
module ft2232h_axil_mem_responder #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 6,
    parameter int MEM_DEPTH          = 16
) (
    input  logic                              ACLK,
    input  logic                              ARESET,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
    input  logic [2:0]                        S_AXI_AWPROT,
    input  logic                              S_AXI_AWVALID,
    output logic                              S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
    input  logic                              S_AXI_WVALID,
    output logic                              S_AXI_WREADY,
    output logic [1:0]                        S_AXI_BRESP,
    output logic                              S_AXI_BVALID,
    input  logic                              S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
    input  logic [2:0]                        S_AXI_ARPROT,
    input  logic                              S_AXI_ARVALID,
    output logic                              S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
    output logic [1:0]                        S_AXI_RRESP,
    output logic                              S_AXI_RVALID,
    input  logic                              S_AXI_RREADY
);
    localparam int IDX_W  = C_S_AXI_ADDR_WIDTH - 2;
    localparam int STRB_W = C_S_AXI_DATA_WIDTH / 8;
    localparam int MI_W   = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic { W_IDLE, W_RESP } w_state_t;
    typedef enum logic { R_IDLE, R_RESP } r_state_t;

    w_state_t w_state_q, w_state_d;
    r_state_t r_state_q, r_state_d;
    logic                          aw_flag_q, aw_flag_d, w_flag_q, w_flag_d;
    logic [IDX_W-1:0]              aw_idx_q, aw_idx_d;
    logic [C_S_AXI_DATA_WIDTH-1:0] w_data_q, w_data_d;
    logic [STRB_W-1:0]             w_strb_q, w_strb_d;
    logic                          bvalid_q, bvalid_d, rvalid_q, rvalid_d;
    logic [1:0]                    bresp_q, bresp_d, rresp_q, rresp_d;
    logic [C_S_AXI_DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [C_S_AXI_DATA_WIDTH-1:0] mem_q [MEM_DEPTH];
    logic [C_S_AXI_DATA_WIDTH-1:0] mem_d [MEM_DEPTH];

    logic                          aw_hs, w_hs, ar_hs;
    logic [IDX_W-1:0]              wr_idx, rd_idx;
    logic [C_S_AXI_DATA_WIDTH-1:0] wr_data;
    logic [STRB_W-1:0]             wr_strb;
    logic                          unused_ok;

    assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

    function automatic logic in_range(input logic [IDX_W-1:0] idx);
        return 32'(idx) < 32'(MEM_DEPTH);
    endfunction

    assign S_AXI_AWREADY = (w_state_q == W_IDLE) && !aw_flag_q;
    assign S_AXI_WREADY  = (w_state_q == W_IDLE) && !w_flag_q;
    assign S_AXI_ARREADY = (r_state_q == R_IDLE);
    assign S_AXI_BVALID  = bvalid_q;
    assign S_AXI_BRESP   = bresp_q;
    assign S_AXI_RVALID  = rvalid_q;
    assign S_AXI_RRESP   = rresp_q;
    assign S_AXI_RDATA   = rdata_q;

    assign aw_hs = S_AXI_AWVALID && S_AXI_AWREADY;
    assign w_hs  = S_AXI_WVALID && S_AXI_WREADY;
    assign ar_hs = S_AXI_ARVALID && S_AXI_ARREADY;

    // A channel that handshakes this cycle is used directly, so the commit lands on the later handshake edge.
    assign wr_idx  = aw_flag_q ? aw_idx_q : S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
    assign wr_data = w_flag_q ? w_data_q : S_AXI_WDATA;
    assign wr_strb = w_flag_q ? w_strb_q : S_AXI_WSTRB;
    assign rd_idx  = S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2];

    always_comb begin
        w_state_d = w_state_q;
        aw_flag_d = aw_flag_q;
        aw_idx_d  = aw_idx_q;
        w_flag_d  = w_flag_q;
        w_data_d  = w_data_q;
        w_strb_d  = w_strb_q;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        mem_d     = mem_q;
        case (w_state_q)
            W_IDLE: begin
                if ((aw_flag_q || aw_hs) && (w_flag_q || w_hs)) begin
                    aw_flag_d = 1'b0;
                    w_flag_d  = 1'b0;
                    bvalid_d  = 1'b1;
                    w_state_d = W_RESP;
                    if (in_range(wr_idx)) begin
                        bresp_d = RESP_OKAY;
                        for (int b = 0; b < STRB_W; b++) begin
                            if (wr_strb[b]) begin
                                mem_d[MI_W'(wr_idx)][8*b +: 8] = wr_data[8*b +: 8];
                            end
                        end
                    end else begin
                        bresp_d = RESP_SLVERR;
                    end
                end else begin
                    if (aw_hs) begin
                        aw_flag_d = 1'b1;
                        aw_idx_d  = S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
                    end
                    if (w_hs) begin
                        w_flag_d = 1'b1;
                        w_data_d = S_AXI_WDATA;
                        w_strb_d = S_AXI_WSTRB;
                    end
                end
            end
            W_RESP: begin
                if (S_AXI_BREADY) begin
                    bvalid_d  = 1'b0;
                    w_state_d = W_IDLE;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    // Reads sample mem_q, so a read on the same edge as a commit sees pre-write data.
    always_comb begin
        r_state_d = r_state_q;
        rvalid_d  = rvalid_q;
        rresp_d   = rresp_q;
        rdata_d   = rdata_q;
        case (r_state_q)
            R_IDLE: begin
                if (ar_hs) begin
                    rvalid_d  = 1'b1;
                    r_state_d = R_RESP;
                    if (in_range(rd_idx)) begin
                        rdata_d = mem_q[MI_W'(rd_idx)];
                        rresp_d = RESP_OKAY;
                    end else begin
                        rdata_d = '0;
                        rresp_d = RESP_SLVERR;
                    end
                end
            end
            R_RESP: begin
                if (S_AXI_RREADY) begin
                    rvalid_d  = 1'b0;
                    r_state_d = R_IDLE;
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            w_state_q <= W_IDLE;
            r_state_q <= R_IDLE;
            aw_flag_q <= 1'b0;
            aw_idx_q  <= '0;
            w_flag_q  <= 1'b0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
            rvalid_q  <= 1'b0;
            rresp_q   <= RESP_OKAY;
            rdata_q   <= '0;
            for (int i = 0; i < MEM_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            w_state_q <= w_state_d;
            r_state_q <= r_state_d;
            aw_flag_q <= aw_flag_d;
            aw_idx_q  <= aw_idx_d;
            w_flag_q  <= w_flag_d;
            w_data_q  <= w_data_d;
            w_strb_q  <= w_strb_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            rvalid_q  <= rvalid_d;
            rresp_q   <= rresp_d;
            rdata_q   <= rdata_d;
            mem_q     <= mem_d;
        end
    end
endmodule

// File: tb/tb_ft2232h_axil_mem_responder.sv
// tb/tb_ft2232h_axil_mem_responder.sv - directed self-checking bench for the AXI4-Lite memory responder
module tb_ft2232h_axil_mem_responder;
    localparam int AW = 7;

    logic          aclk = 1'b0;
    logic          areset = 1'b1;
    logic [AW-1:0] awaddr = '0, araddr = '0;
    logic          awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0, arvalid = 1'b0, rready = 1'b0;
    logic [31:0]   wdata = '0;
    logic [3:0]    wstrb = '0;
    logic          awready, wready, bvalid, arready, rvalid;
    logic [1:0]    bresp, rresp;
    logic [31:0]   rdata;
    logic [31:0]   rd;
    logic [1:0]    rs;
    int            n_checks = 0;
    int            n_errors = 0;

    always #5 aclk = ~aclk;

    ft2232h_axil_mem_responder #(
        .C_S_AXI_DATA_WIDTH(32),
        .C_S_AXI_ADDR_WIDTH(AW),
        .MEM_DEPTH(16)
    ) dut (
        .ACLK(aclk), .ARESET(areset),
        .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(3'b000), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
        .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
        .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
        .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(3'b000), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
        .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic axi_write(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] s,
                             output logic [1:0] resp);
        int  n = 0;
        logic aw_hs, w_hs;
        awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
        while ((awvalid || wvalid) && n < 20) begin
            aw_hs = awvalid && awready;
            w_hs  = wvalid && wready;
            @(negedge aclk);
            if (aw_hs) awvalid = 1'b0;
            if (w_hs)  wvalid  = 1'b0;
            n++;
        end
        chk("wr_accept", {30'b0, awvalid, wvalid}, 32'h0);
        awvalid = 1'b0; wvalid = 1'b0;
        bready = 1'b1;
        n = 0;
        while (!bvalid && n < 20) begin
            @(negedge aclk);
            n++;
        end
        chk("wr_bvalid", {31'b0, bvalid}, 32'h1);
        resp = bresp;
        @(negedge aclk);
        bready = 1'b0;
    endtask

    task automatic axi_read(input logic [AW-1:0] a, output logic [31:0] d, output logic [1:0] resp);
        int  n = 0;
        logic ar_hs = 1'b0;
        araddr = a; arvalid = 1'b1;
        while (!ar_hs && n < 20) begin
            ar_hs = arready;
            @(negedge aclk);
            n++;
        end
        arvalid = 1'b0;
        chk("rd_accept", {31'b0, ar_hs}, 32'h1);
        chk("rd_latency", {31'b0, rvalid}, 32'h1);
        rready = 1'b1;
        n = 0;
        while (!rvalid && n < 20) begin
            @(negedge aclk);
            n++;
        end
        d = rdata;
        resp = rresp;
        @(negedge aclk);
        rready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // 1: reset state and cleared memory
        repeat (3) @(negedge aclk);
        chk("rst_ctl", {27'b0, awready, wready, arready, bvalid, rvalid}, 32'h1C);
        chk("rst_resp", {28'b0, bresp, rresp}, 32'h0);
        chk("rst_rdata", rdata, 32'h0);
        areset = 1'b0;
        @(negedge aclk);
        chk("post_rst_ctl", {27'b0, awready, wready, arready, bvalid, rvalid}, 32'h1C);
        for (int i = 0; i < 16; i++) begin
            axi_read(AW'(i * 4), rd, rs);
            chk("rst_mem", {rs, rd[29:0]} ^ {2'b0, rd[31:30] ^ rd[31:30], 30'b0}, 32'h0);
            chk("rst_mem_hi", {30'b0, rd[31:30]}, 32'h0);
        end

        // 2: AW, then W two cycles later
        awaddr = 7'h04; awvalid = 1'b1;
        chk("t2_awready0", {31'b0, awready}, 32'h1);
        @(negedge aclk);
        awvalid = 1'b0;
        chk("t2_awready_drop", {31'b0, awready}, 32'h0);
        chk("t2_no_b_early", {31'b0, bvalid}, 32'h0);
        @(negedge aclk);
        wdata = 32'hDEADBEEF; wstrb = 4'hF; wvalid = 1'b1;
        chk("t2_wready", {31'b0, wready}, 32'h1);
        @(negedge aclk);
        wvalid = 1'b0;
        chk("t2_b", {28'b0, bvalid, bresp, awready}, 32'h8);
        chk("t2_wready_resp", {31'b0, wready}, 32'h0);
        bready = 1'b1;
        @(negedge aclk);
        bready = 1'b0;
        chk("t2_after_b", {29'b0, bvalid, awready, wready}, 32'h3);
        axi_read(7'h04, rd, rs);
        chk("t2_rdata", rd, 32'hDEADBEEF);
        chk("t2_rresp", {30'b0, rs}, 32'h0);

        // 3: W before AW with partial strobes
        axi_write(7'h08, 32'hDEADBEEF, 4'hF, rs);
        chk("t3_pre_bresp", {30'b0, rs}, 32'h0);
        wdata = 32'h11223344; wstrb = 4'b0101; wvalid = 1'b1;
        @(negedge aclk);
        wvalid = 1'b0;
        chk("t3_w_held", {29'b0, wready, awready, bvalid}, 32'h2);
        awaddr = 7'h08; awvalid = 1'b1;
        @(negedge aclk);
        awvalid = 1'b0;
        chk("t3_b", {29'b0, bvalid, bresp}, 32'h4);
        bready = 1'b1;
        @(negedge aclk);
        bready = 1'b0;
        axi_read(7'h08, rd, rs);
        chk("t3_merge", rd, 32'hDE22BE44);

        // 4: last word, out-of-range word, unaligned address, empty strobe
        axi_write(7'h3C, 32'hCAFEF00D, 4'hF, rs);
        chk("t4_w15_bresp", {30'b0, rs}, 32'h0);
        axi_read(7'h3C, rd, rs);
        chk("t4_w15_rdata", rd, 32'hCAFEF00D);
        chk("t4_w15_rresp", {30'b0, rs}, 32'h0);
        axi_write(7'h40, 32'h12345678, 4'hF, rs);
        chk("t4_oor_bresp", {30'b0, rs}, 32'h2);
        axi_read(7'h40, rd, rs);
        chk("t4_oor_rdata", rd, 32'h0);
        chk("t4_oor_rresp", {30'b0, rs}, 32'h2);
        axi_read(7'h00, rd, rs);
        chk("t4_w0_intact", rd, 32'h0);
        axi_write(7'h3C, 32'hFFFFFFFF, 4'h0, rs);
        chk("t4_nostrb_bresp", {30'b0, rs}, 32'h0);
        axi_read(7'h3E, rd, rs);
        chk("t4_unaligned", rd, 32'hCAFEF00D);

        // 5: stalled BREADY with a concurrent read
        awaddr = 7'h10; awvalid = 1'b1; wdata = 32'hA5A5A5A5; wstrb = 4'hF; wvalid = 1'b1;
        @(negedge aclk);
        awvalid = 1'b0; wvalid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("t5_stall", {27'b0, bvalid, bresp, awready, wready}, 32'h10);
            @(negedge aclk);
        end
        axi_read(7'h04, rd, rs);
        chk("t5_conc_read", rd, 32'hDEADBEEF);
        for (int i = 0; i < 4; i++) begin
            chk("t5_stall2", {27'b0, bvalid, bresp, awready, wready}, 32'h10);
            @(negedge aclk);
        end
        bready = 1'b1;
        @(negedge aclk);
        bready = 1'b0;
        axi_read(7'h10, rd, rs);
        chk("t5_stalled_wr", rd, 32'hA5A5A5A5);

        axi_write(7'h14, 32'h01010101, 4'hF, rs);
        awaddr = 7'h14; awvalid = 1'b1; wdata = 32'h02020202; wvalid = 1'b1;
        araddr = 7'h14; arvalid = 1'b1;
        @(negedge aclk);
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        chk("t5_coll_valid", {30'b0, bvalid, rvalid}, 32'h3);
        chk("t5_coll_old", rdata, 32'h01010101);
        bready = 1'b1; rready = 1'b1;
        @(negedge aclk);
        bready = 1'b0; rready = 1'b0;
        axi_read(7'h14, rd, rs);
        chk("t5_coll_new", rd, 32'h02020202);

        // 6: asynchronous reset with both responses pending
        awaddr = 7'h18; awvalid = 1'b1; wdata = 32'h00000077; wvalid = 1'b1;
        araddr = 7'h04; arvalid = 1'b1;
        @(negedge aclk);
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        chk("t6_pending", {30'b0, bvalid, rvalid}, 32'h3);
        #2 areset = 1'b1;
        #1;
        chk("t6_async_drop", {27'b0, awready, wready, arready, bvalid, rvalid}, 32'h1C);
        chk("t6_rdata_clr", rdata, 32'h0);
        @(negedge aclk);
        areset = 1'b0;
        bready = 1'b1; rready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge aclk);
            chk("t6_no_stale", {30'b0, bvalid, rvalid}, 32'h0);
        end
        bready = 1'b0; rready = 1'b0;
        axi_read(7'h04, rd, rs);
        chk("t6_mem04", rd, 32'h0);
        axi_read(7'h18, rd, rs);
        chk("t6_mem18", rd, 32'h0);
        axi_read(7'h3C, rd, rs);
        chk("t6_mem3c", rd, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
